// File: rtl/lifting_dwt_stream.sv
// lifting_dwt_stream
// Single-clock integer lifting wavelet stage. A valid-qualified stream of
// signed samples is split into an approximation stream (out_s) and a detail
// stream (out_d) at half the input rate. The half rate is carried by the
// single-cycle out_valid strobe, so there is no divided clock.
// The mode is latched while rst is high: LeGall 5/3 lifting (mode_53 = 1) or
// Haar lifting (mode_53 = 0).
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; also latches mode_53
//   mode_53    1 = 5/3 lifting, 0 = Haar lifting (only sampled during rst)
//   in_valid   in_data is consumed this cycle (no backpressure)
//   in_data    signed sample x[k], DATA_W bits
//   out_valid  one-cycle strobe marking an (s, d) pair
//   out_s      signed approximation coefficient, OUT_W bits
//   out_d      signed detail coefficient, OUT_W bits
//   out_first  high with out_valid on the first pair after reset
module lifting_dwt_stream #(
   parameter  int DATA_W = 32,
   localparam int OUT_W  = DATA_W + 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode_53,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  out_s,
   output logic signed [OUT_W-1:0]  out_d,
   output logic                     out_first
);

   localparam int SUM_W = DATA_W + 4;
   localparam logic signed [SUM_W-1:0] ROUND_53 = 2;

   typedef enum logic [1:0] {
      FIRST,
      ODD,
      EVEN,
      HAAR_EVEN
   } state_t;

   state_t state, state_n;

   logic                     mode_q;
   logic                     first_flag;
   logic signed [DATA_W-1:0] x_even;
   logic signed [DATA_W-1:0] x_odd;
   logic signed [OUT_W-1:0]  d_prev;

   logic load_even;
   logic load_odd;
   logic emit;

   // Widened operands so no intermediate sum can wrap.
   logic signed [SUM_W-1:0] xe, xo, xn, dp;
   logic signed [SUM_W-1:0] d_53, d_left, s_53;
   logic signed [SUM_W-1:0] d_haar, s_haar;
   logic signed [OUT_W-1:0] s_next, d_next;

   assign xe = {{4{x_even[DATA_W-1]}}, x_even};
   assign xo = {{4{x_odd[DATA_W-1]}}, x_odd};
   assign xn = {{4{in_data[DATA_W-1]}}, in_data};
   assign dp = {{2{d_prev[OUT_W-1]}}, d_prev};

   // >>> on signed operands is floor division, never truncation toward zero.
   assign d_53   = xo - ((xe + xn) >>> 1);
   // Symmetric left extension: the first pair uses d[0] as its own d[-1].
   assign d_left = first_flag ? d_53 : dp;
   assign s_53   = xe + ((d_left + d_53 + ROUND_53) >>> 2);

   // In Haar mode the completing sample is x_odd, still on in_data.
   assign d_haar = xn - xe;
   assign s_haar = xe + (d_haar >>> 1);

   assign s_next = OUT_W'(mode_q ? s_53 : s_haar);
   assign d_next = OUT_W'(mode_q ? d_53 : d_haar);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of process ordering.
      if (rst) state <= FIRST;
      else     state <= state_n;
   end

   // Next state and datapath strobes; only an accepted sample moves the FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise the
      // paths that do not assign it would infer a latch.
      state_n   = state;
      load_even = 1'b0;
      load_odd  = 1'b0;
      emit      = 1'b0;
      if (in_valid) begin
         unique case (state)
            FIRST, HAAR_EVEN: begin
               load_even = 1'b1;
               state_n   = ODD;
            end
            ODD: begin
               load_odd = 1'b1;
               if (mode_q) begin
                  state_n = EVEN;
               end else begin
                  emit    = 1'b1;
                  state_n = HAAR_EVEN;
               end
            end
            EVEN: begin
               // x[2n+2] closes pair n and becomes the next x_even.
               load_even = 1'b1;
               emit      = 1'b1;
               state_n   = ODD;
            end
            default: state_n = FIRST;
         endcase
      end
   end

   // Sample registers, d_prev, mode latch and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the sample and d_prev registers are cleared on reset so a
         // dropped partial pair can never leak into the next stream.
         mode_q     <= mode_53;
         first_flag <= 1'b1;
         x_even     <= '0;
         x_odd      <= '0;
         d_prev     <= '0;
         out_valid  <= 1'b0;
         out_s      <= '0;
         out_d      <= '0;
         out_first  <= 1'b0;
      end else begin
         out_valid <= emit;
         out_first <= emit & first_flag;
         if (emit) begin
            out_s      <= s_next;
            out_d      <= d_next;
            first_flag <= 1'b0;
            if (mode_q) d_prev <= OUT_W'(d_53);
         end
         if (load_even) x_even <= in_data;
         if (load_odd)  x_odd  <= in_data;
      end
   end

endmodule

// File: doc/lifting_dwt_stream.md
# lifting_dwt_stream

Single-clock, parametrised integer lifting wavelet stage for the ECG pipeline. It takes a valid-qualified stream of signed samples and splits it into an approximation stream (s) and a detail stream (d) at half the input rate. The block runs in one of two modes, selected at reset: LeGall 5/3 lifting or Haar lifting. It replaces the two-clock lifting arrangement: the downsampled rate is carried by `out_valid` strobes, and there is no separate divided clock.

## Interface
Parameters:
- DATA_W, 32, signed input sample width.
- OUT_W, DATA_W+2, signed output width. This value is derived and must not be overridden.

Ports:
- clk  in  1  sole clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_53  in  1  1 selects 5/3 mode, 0 selects Haar mode. Sampled on every cycle that rst is high; ignored otherwise.
- in_valid  in  1  in_data is accepted on this cycle. There is no backpressure: every valid sample is consumed.
- in_data  in  DATA_W  signed sample x[k].
- out_valid  out  1  single-cycle strobe marking an (s, d) pair.
- out_s  out  OUT_W  signed approximation coefficient.
- out_d  out  OUT_W  signed detail coefficient.
- out_first  out  1  high together with out_valid for the first pair after reset.

## Operation
- All arithmetic is signed.
- Internal sums are DATA_W+4 bits wide.
- floor(v/2^n) is implemented as an arithmetic right shift; it is never truncation toward zero.

5/3 mode:
- d[n] = x[2n+1] − floor((x[2n] + x[2n+2]) / 2).
- s[n] = x[2n] + floor((d[n−1] + d[n] + 2) / 4).
- Left boundary uses symmetric extension: d[−1] = d[0].
- The stream is treated as continuous. There is no right-boundary flush; the last pending even/odd samples are discarded by reset.

Haar mode:
- d[n] = x[2n+1] − x[2n].
- s[n] = x[2n] + floor(d[n] / 2).

FSM states (each transition happens on an accepted sample):
- FIRST: after reset. An accepted sample is stored as x_even and the FSM goes to ODD.
- ODD: an accepted sample is stored as x_odd.
  - In 5/3 mode, go to EVEN.
  - In Haar mode, compute the pair, go to HAAR_EVEN, and emit.
- EVEN (5/3 only): the accepted sample is x[2n+2].
  - Compute d[n] and s[n].
  - Set d_prev ← d[n] and x_even ← x[2n+2].
  - Go to ODD and emit.
- HAAR_EVEN: an accepted sample is stored as x_even and the FSM goes to ODD.

Flags and input gaps:
- first_flag is set by reset. It is cleared after the first emit. While it is set, d_prev is replaced by the current d[n].
- Cycles with in_valid low leave all state unchanged, so gaps of any length are allowed.
- in_valid may be high on every cycle; the sustained output is one pair per 2 input samples.

Reset:
- While rst is high, out_valid, out_s, out_d and out_first are 0, the state is FIRST, and all sample and d_prev registers are 0.
- A reset in the middle of a pair drops the partial pair.
- in_valid on a reset cycle is ignored.

## Timing
- Outputs are registered.
  - out_valid rises exactly 1 cycle after the clock edge that accepts the completing sample: x[2n+2] in 5/3 mode, x[2n+1] in Haar mode.
  - out_valid is high for exactly 1 cycle.
- out_s and out_d hold their last values between strobes.
- 5/3 mode has 1 sample of look-ahead: pair n appears only after x[2n+2] is accepted.
- mode_53 changes made outside reset have no effect until the next reset.

## Test plan
- 5/3 basic, DATA_W=32, x = 4, 8, 2, 6, 0 on back-to-back valids:
  - Pair 0 is (s=7, d=5) with out_first=1, 1 cycle after the 3rd sample.
  - Pair 1 is (s=5, d=5) with out_first=0, 1 cycle after the 5th sample.
- 5/3 negative floor, x = −3, 0, −4 → (s=−1, d=4). This checks floor(−7/2) = −4.
- Haar mode, rst with mode_53=0:
  - x = 10, 3 → (s=6, d=−7).
  - x = −5, −4 → (s=−5, d=1).
- 5/3 full scale, DATA_W=32, x = 2^31−1, −2^31, 2^31−1 → d = −2^32+1 with no wrap in OUT_W=34, and s = 0.
- Valid gaps and reset:
  - Run 5/3 x = 4, 8, 2, 6, 0 with random in_valid gaps of 0–5 cycles; the result must be identical pairs, and there must be no out_valid while no sample is accepted.
  - Assert rst after x=4, 8 only; the next stream 4, 8, 2 must yield (7, 5) with out_first=1.
